// File: rtl/div_unit.sv
// Multicycle signed 32-bit restoring divider: quotient lands in lo, remainder in hi.
// Handshake: start is sampled only in IDLE; done pulses for one cycle in DONE, where hi/lo/div_zero are valid.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div_zero_q, div_zero_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      dvs_mag_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      dz_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      dvs_mag_q  <= dvs_mag_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
      dz_pend_q  <= dz_pend_d;
    end
  end

  // A zero divisor holds SETUP for one extra cycle so DONE is entered on edge 2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: begin
        if (dvs_q != '0)    state_d = S_ITER;
        else if (dz_pend_q) state_d = S_DONE;
      end
      S_ITER:  if (cnt_q == 5'd0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag_q};

  always_comb begin
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    dvs_mag_d  = dvs_mag_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    dz_pend_d  = dz_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
        end
      end
      S_SETUP: begin
        if (dvs_q == '0) begin
          div_zero_d = dz_pend_q;
          dz_pend_d  = ~dz_pend_q;
        end else begin
          quo_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
          dvs_mag_d = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
          q_neg_d   = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          r_neg_d   = dvd_q[WIDTH-1];
          rem_d     = '0;
          cnt_d     = 5'd31;
        end
      end
      S_ITER: begin
        // The partial remainder stays below |divisor| <= 2^31, so trial[WIDTH] is a true sign bit.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
      S_FIX: begin
        lo_d = q_neg_q ? -quo_q : quo_q;
        hi_d = r_neg_q ? -rem_q : rem_q;
      end
      S_DONE:  div_zero_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, a negedge monitor pops on done.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_busy_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          checks = 0, passes = 0;
  int          e0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference model: plain 64-bit signed arithmetic, truncating division.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    int     to;
    to = 0;
    @(negedge clk);
    while (busy && to < 300) begin
      @(negedge clk);
      to++;
    end
    if (busy) chk("issue_timeout", 1, 0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (b == 32'd0) begin
      exp_q.push_back({1'b1, m_hi, m_lo});
      exp_cyc_q.push_back(e0 + 2);
      exp_busy_q.push_back(3);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa - q * sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      exp_q.push_back({1'b0, m_hi, m_lo});
      exp_cyc_q.push_back(e0 + 34);
      exp_busy_q.push_back(35);
    end
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_idle();
    int to;
    to = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && to < 300) begin
      @(negedge clk);
      to++;
    end
    if (busy || exp_q.size() != 0) chk("idle_timeout", 1, 0);
  endtask

  int          run = 0;
  bit          post_done = 0;
  logic [31:0] prev_hi = '0, prev_lo = '0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_cyc_q.delete();
      exp_busy_q.delete();
      run = 0;
      post_done = 0;
      prev_hi = '0;
      prev_lo = '0;
    end else begin
      if (post_done) begin
        chk("done_one_cycle", {64'd0, done}, 65'd0);
        chk("div_zero_clear", {64'd0, div_zero}, 65'd0);
        post_done = 0;
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("result{dz,hi,lo}", {div_zero, hi, lo}, exp_q.pop_front());
          chk("done_edge", 65'(cyc), 65'(exp_cyc_q.pop_front()));
        end
        post_done = 1;
      end else if ({hi, lo} !== {prev_hi, prev_lo}) begin
        chk("hilo_stable", {1'b0, hi, lo}, {1'b0, prev_hi, prev_lo});
      end
      prev_hi = hi;
      prev_lo = lo;
      if (busy) run++;
      else if (run > 0) begin
        if (exp_busy_q.size() == 0) chk("busy_unexpected", 65'(run), 0);
        else chk("busy_len", 65'(run), 65'(exp_busy_q.pop_front()));
        run = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    #2;
    chk("rst_hi", {33'd0, hi}, 65'd0);
    chk("rst_lo", {33'd0, lo}, 65'd0);
    chk("rst_flags", {62'd0, busy, done, div_zero}, 65'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    issue(32'd7, 32'd2);           wait_idle();
    issue(-32'sd7, 32'd2);         wait_idle();
    issue(32'd7, -32'sd2);         wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(32'd5, 32'd9);           wait_idle();
    issue(32'd7, 32'd2);           wait_idle();
    issue(32'd10, 32'd0);          wait_idle();
    chk("dz_hold_hi", {33'd0, hi}, 65'd1);
    chk("dz_hold_lo", {33'd0, lo}, 65'd3);

    // Second start lands at edge 10 of 100/7 and must be ignored.
    issue(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset at edge 20 of 1000/3 aborts the operation.
    issue(32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_hi", {33'd0, hi}, 65'd0);
    chk("abort_lo", {33'd0, lo}, 65'd0);
    chk("abort_flags", {62'd0, busy, done, div_zero}, 65'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(32'd9, 32'd3);           wait_idle();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 40);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = 32'h8000_0000;
        4: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      issue(a, b);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multicycle 32-bit signed integer divider for the multicycle datapath. It accepts a dividend/divisor pair on a start pulse and runs a restoring shift-subtract algorithm, one quotient bit per cycle. It latches quotient into `lo` and remainder into `hi`. Both registers feed data inputs of the 8-input 32-bit write-back select mux directly downstream, and the control unit's selector picks them on MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported; the iteration counter is sized for it.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs immediately.
- `start`  in  1  one-cycle request from the control unit. Sampled only in IDLE.
- `dividend`  in  32  signed numerator, captured at the start edge.
- `divisor`  in  32  signed denominator, captured at the start edge.
- `hi`  out  32  remainder register; holds its value between operations.
- `lo`  out  32  quotient register; holds its value between operations.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse; high only in DONE.
- `div_zero`  out  1  exception flag to the control unit; valid while `done`=1.

## Operation
- Reset values:
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0.
  - State is IDLE, the counter is 0, and internal operand registers are 0.
- FSM states: IDLE, SETUP, ITER, FIX, DONE.
- **IDLE**
  - On `start`=1, capture `dividend` and `divisor`, then go to SETUP.
  - `start` pulses in any other state are ignored and are not queued.
- **SETUP**
  - If the captured divisor is 0: set `div_zero`, go to DONE, leave `hi`/`lo` unchanged.
  - Otherwise: load the magnitudes |dividend| and |divisor| as unsigned 32-bit values (|0x80000000| = 0x80000000).
  - Record `q_neg` = sign(dividend) XOR sign(divisor), and `r_neg` = sign(dividend).
  - Clear the 33-bit partial remainder and set the counter to 31. Go to ITER.
- **ITER**, each cycle:
  - Shift {rem, quo} left by 1, bringing the quotient MSB into rem.
  - Trial subtract rem − |divisor| in 33 bits.
  - If the result is non-negative, set rem to the result and set the quotient LSB to 1. Otherwise keep rem and set the LSB to 0.
  - When the counter is 0, go to FIX; otherwise decrement the counter.
  - ITER runs exactly 32 cycles.
- **FIX**
  - `lo` ← `q_neg` ? −quo : quo.
  - `hi` ← `r_neg` ? −rem : rem.
  - Go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
  - `div_zero` is cleared on leaving DONE.
- Arithmetic rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend and satisfies |hi| < |divisor|.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. No trap is raised.
- `hi`/`lo` change only in the FIX cycle, so the write-back mux never sees partial results.

## Timing
- Label the rising edge that samples `start`=1 in IDLE as edge 0.
- Normal operation:
  - SETUP after edge 0.
  - ITER after edges 1..32.
  - FIX after edge 33.
  - `hi`/`lo` updated at edge 34, which is the same edge that enters DONE.
  - `done` high between edges 34 and 35.
  - IDLE after edge 35; a new `start` is accepted at edge 36 at the earliest.
- `busy` rises after edge 0 and falls after edge 35.
- Divide by zero: DONE is entered at edge 2, `done` and `div_zero` are high between edges 2 and 3, and IDLE follows after edge 3.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values and no `done` pulse is produced. The operation is not resumed after reset releases.
- `start` during SETUP, ITER, FIX or DONE has no effect. Captured operands are unaffected by later input changes.

## Test plan
- Reset then 7 / 2 → `done` at edge 34, `lo`=3, `hi`=1, `div_zero`=0. `busy` is high for exactly 35 cycles.
- −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Also 7 / −2 → `lo`=0xFFFFFFFD, `hi`=1.
- 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Also 5 / 9 → `lo`=0, `hi`=5.
- Divide by zero, with prior `hi`=1, `lo`=3 and 10 / 0 → `done`=`div_zero`=1 at edge 2, `hi`/`lo` stay 1/3, `div_zero`=0 one cycle later.
- Start while busy, 100 / 7 then `start` pulsed at edge 10 with 1 / 1 → result `lo`=14, `hi`=2, exactly one `done`, `busy` falls after edge 35.
- `reset` pulled low at edge 20 during 1000 / 3 → outputs and `busy` are 0 immediately. A subsequent 9 / 3 completes normally with `lo`=3, `hi`=0.
